// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and the fill-state encoding for the cache line-fill controller.
package cache_pkg;
  localparam int ADDR_W_DEF     = 16;
  localparam int OFF_W_DEF      = 3;
  localparam int BYTE_OFF_W_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Memory-side request/return handshake between the fill controller and the memory.
interface cache_fill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_data_valid;

  modport master (
    output mem_req_valid,
    output mem_address,
    input  mem_req_ready,
    input  mem_data_valid
  );

  modport slave (
    input  mem_req_valid,
    input  mem_address,
    output mem_req_ready,
    output mem_data_valid
  );
endinterface

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Up-counter with enable and synchronous clear; clear has priority over enable.
module fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/cache_fill_ctrl.sv
// Critical-word-first line-fill controller with request handshake, outstanding cap and early restart.
//   state | meaning
//   IDLE  | waiting for a miss; counters hold, outputs quiet
//   FILL  | issuing word requests and writing returned words into the line
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OFF_W      = OFF_W_DEF,
  parameter int BYTE_OFF_W = BYTE_OFF_W_DEF,
  parameter int MAX_OUT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_detected,
  input  logic [ADDR_W-1:0]  miss_address,
  cache_fill_ctrl_if.master  mem,
  output logic               fsm_busy,
  output logic               write_data_array,
  output logic [OFF_W-1:0]   write_offset,
  output logic               write_tag_array,
  output logic               critical_valid
);
  localparam int WORDS  = 2 ** OFF_W;
  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int BASE_W = ADDR_W - OFF_W - BYTE_OFF_W;

  localparam logic [OFF_W:0]     WORDS_C   = (OFF_W+1)'(WORDS);
  localparam logic [OFF_W:0]     LAST_C    = (OFF_W+1)'(WORDS - 1);
  localparam logic [OUT_W-1:0]   MAX_OUT_C = OUT_W'(MAX_OUT);

  fill_state_e       state_q;
  logic [BASE_W-1:0] base_q;
  logic [OFF_W-1:0]  start_q;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [OFF_W:0]    req_cnt, rcv_cnt;
  logic              start_fill, accept, receive, last_rcv;
  logic              unused_byte_bits;

  assign unused_byte_bits = ^miss_address[BYTE_OFF_W-1:0];

  assign start_fill = (state_q == IDLE) && miss_detected;

  assign mem.mem_req_valid = (state_q == FILL) && (req_cnt < WORDS_C) && (out_cnt_q < MAX_OUT_C);
  assign accept            = mem.mem_req_valid && mem.mem_req_ready;
  // A return with nothing outstanding cannot belong to this fill, so it is dropped.
  assign receive           = (state_q == FILL) && mem.mem_data_valid && (out_cnt_q != '0);
  assign last_rcv          = receive && (rcv_cnt == LAST_C);

  assign mem.mem_address = {base_q, start_q + req_cnt[OFF_W-1:0], {BYTE_OFF_W{1'b0}}};

  fill_counter #(.WIDTH(OFF_W + 1)) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_fill),
    .en    (accept),
    .count (req_cnt)
  );

  fill_counter #(.WIDTH(OFF_W + 1)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_fill),
    .en    (receive),
    .count (rcv_cnt)
  );

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (start_fill) begin
      out_cnt_d = '0;
    end else if (accept && !receive) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (receive && !accept) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            state_q <= FILL;
            base_q  <= miss_address[ADDR_W-1:OFF_W+BYTE_OFF_W];
            start_q <= miss_address[OFF_W+BYTE_OFF_W-1:BYTE_OFF_W];
          end
        end
        FILL: begin
          if (last_rcv) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = (state_q == FILL);
  assign write_data_array = receive;
  assign write_offset     = start_q + rcv_cnt[OFF_W-1:0];
  assign write_tag_array  = last_rcv;
  assign critical_valid   = receive && (rcv_cnt == '0);
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl with a small latency-queue memory model.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy, write_data_array, write_tag_array, critical_valid;
  logic [2:0]  write_offset;

  cache_fill_ctrl_if #(.ADDR_W(16)) mem_if ();

  cache_fill_ctrl #(.ADDR_W(16), .OFF_W(3), .BYTE_OFF_W(1), .MAX_OUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem              (mem_if),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_offset     (write_offset),
    .write_tag_array  (write_tag_array),
    .critical_valid   (critical_valid)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // next-cycle stimulus, applied inside tick() just after the rising edge
  bit          rdy_n = 1'b0, miss_n = 1'b0, auto_ret = 1'b0, dv_man = 1'b0;
  logic [15:0] addr_n = '0;
  int          lat = 4;
  int          cyc = 0;
  int          due_q[$];
  logic [15:0] acc_log[$];
  logic [4:0]  wr_log[$];

  bit          obs_valid, obs_busy, obs_write, obs_tag, obs_crit, obs_acc;
  logic [15:0] obs_addr;
  logic [2:0]  obs_off;

  logic [15:0] seq_1234 [8] = '{16'h1234, 16'h1236, 16'h1238, 16'h123A,
                                16'h123C, 16'h123E, 16'h1230, 16'h1232};
  logic [2:0]  off_1234 [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic [15:0] seq_00f0 [8] = '{16'h00F0, 16'h00F2, 16'h00F4, 16'h00F6,
                                16'h00F8, 16'h00FA, 16'h00FC, 16'h00FE};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    miss_detected        = miss_n;
    miss_address         = addr_n;
    mem_if.mem_req_ready = rdy_n;
    if (auto_ret) mem_if.mem_data_valid = (due_q.size() > 0) && (due_q[0] <= cyc);
    else          mem_if.mem_data_valid = dv_man;
    if (mem_if.mem_data_valid && due_q.size() > 0) due_q.delete(0);
    #1;
    obs_valid = mem_if.mem_req_valid;
    obs_addr  = mem_if.mem_address;
    obs_busy  = fsm_busy;
    obs_write = write_data_array;
    obs_off   = write_offset;
    obs_tag   = write_tag_array;
    obs_crit  = critical_valid;
    obs_acc   = obs_valid && rdy_n;
    if (obs_acc) begin
      acc_log.push_back(obs_addr);
      due_q.push_back(cyc + lat);
    end
    if (obs_write) wr_log.push_back({obs_tag, obs_crit, obs_off});
  endtask

  task automatic clear_logs();
    acc_log.delete();
    wr_log.delete();
  endtask

  task automatic drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (obs_tag) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({mem_if.mem_req_valid, fsm_busy, write_data_array, write_tag_array, critical_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {mem_if.mem_req_valid, fsm_busy, write_data_array, write_tag_array, critical_valid});
    end
    tests_run++;
    if (mem_if.mem_address !== 16'h0000) begin
      fails++;
      $display("FAIL reset_addr: got %h expected 0000", mem_if.mem_address);
    end
    tests_run++;
    if (write_offset !== 3'd0) begin
      fails++;
      $display("FAIL reset_offset: got %0d expected 0", write_offset);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_crit_first();
    bit to;
    logic [4:0] e;
    clear_logs();
    lat = 4; auto_ret = 1'b1; rdy_n = 1'b1; addr_n = 16'h1234; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    tick();
    tests_run++;
    if (!(obs_valid && obs_busy && obs_addr == 16'h1234)) begin
      fails++;
      $display("FAIL cwf_first_req: got valid=%b busy=%b addr=%h expected 1 1 1234", obs_valid, obs_busy, obs_addr);
    end
    drain(60, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL cwf_timeout: got no tag write expected one"); end
    tests_run++;
    if (acc_log.size() != 8 || wr_log.size() != 8) begin
      fails++;
      $display("FAIL cwf_counts: got acc=%0d wr=%0d expected 8 8", acc_log.size(), wr_log.size());
    end
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      tests_run++;
      if (acc_log[i] !== seq_1234[i]) begin
        fails++;
        $display("FAIL cwf_addr[%0d]: got %h expected %h", i, acc_log[i], seq_1234[i]);
      end
    end
    for (int i = 0; i < wr_log.size() && i < 8; i++) begin
      e = {(i == 7), (i == 0), off_1234[i]};
      tests_run++;
      if (wr_log[i] !== e) begin
        fails++;
        $display("FAIL cwf_write[%0d]: got tag/crit/off %b expected %b", i, wr_log[i], e);
      end
    end
    tick();
    tests_run++;
    if (obs_busy !== 1'b0) begin fails++; $display("FAIL cwf_done_busy: got %b expected 0", obs_busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    lat = 2; auto_ret = 1'b1; rdy_n = 1'b1; addr_n = 16'h1234; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    tick();
    tick();
    rdy_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (!(obs_valid && obs_addr == 16'h1238)) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid=%b addr=%h expected 1 1238", i, obs_valid, obs_addr);
      end
    end
    tests_run++;
    if (acc_log.size() != 2) begin fails++; $display("FAIL bp_acc_count: got %0d expected 2", acc_log.size()); end
    rdy_n = 1'b1;
    tick();
    tests_run++;
    if (!(obs_acc && obs_addr == 16'h1238)) begin
      fails++;
      $display("FAIL bp_resume: got acc=%b addr=%h expected 1 1238", obs_acc, obs_addr);
    end
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8) begin
      fails++;
      $display("FAIL bp_complete: got timeout=%b writes=%0d expected 0 8", to, wr_log.size());
    end
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      tests_run++;
      if (acc_log[i] !== seq_1234[i]) begin
        fails++;
        $display("FAIL bp_addr[%0d]: got %h expected %h", i, acc_log[i], seq_1234[i]);
      end
    end
    tick();
  endtask

  task automatic test_out_cap();
    bit to;
    clear_logs();
    lat = 1; auto_ret = 1'b0; dv_man = 1'b0; rdy_n = 1'b1; addr_n = 16'h2000; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (acc_log.size() != 4 || obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL cap_stall: got acc=%0d valid=%b expected 4 0", acc_log.size(), obs_valid);
    end
    dv_man = 1'b1;
    tick();
    tests_run++;
    if (!(obs_write && obs_crit && obs_off == 3'd0 && !obs_valid)) begin
      fails++;
      $display("FAIL cap_return: got wr=%b crit=%b off=%0d valid=%b expected 1 1 0 0",
               obs_write, obs_crit, obs_off, obs_valid);
    end
    dv_man = 1'b0;
    tick();
    tests_run++;
    if (!(obs_valid && obs_addr == 16'h2008)) begin
      fails++;
      $display("FAIL cap_reissue: got valid=%b addr=%h expected 1 2008", obs_valid, obs_addr);
    end
    tick();
    tests_run++;
    if (obs_valid !== 1'b0 || acc_log.size() != 5) begin
      fails++;
      $display("FAIL cap_one_more: got valid=%b acc=%0d expected 0 5", obs_valid, acc_log.size());
    end
    auto_ret = 1'b1;
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8 || acc_log.size() != 8) begin
      fails++;
      $display("FAIL cap_complete: got timeout=%b writes=%0d acc=%0d expected 0 8 8", to, wr_log.size(), acc_log.size());
    end
    tick();
  endtask

  task automatic test_stray();
    bit to;
    clear_logs();
    auto_ret = 1'b0; dv_man = 1'b1; miss_n = 1'b0; rdy_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (obs_write !== 1'b0 || obs_busy !== 1'b0) begin
        fails++;
        $display("FAIL stray_idle[%0d]: got wr=%b busy=%b expected 0 0", i, obs_write, obs_busy);
      end
    end
    dv_man = 1'b0; auto_ret = 1'b1; lat = 3; addr_n = 16'h1234; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    repeat (3) tick();
    miss_n = 1'b1; addr_n = 16'h4000;
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8 || acc_log.size() != 8) begin
      fails++;
      $display("FAIL stray_fill: got timeout=%b writes=%0d acc=%0d expected 0 8 8", to, wr_log.size(), acc_log.size());
    end
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      tests_run++;
      if (acc_log[i] !== seq_1234[i]) begin
        fails++;
        $display("FAIL stray_addr[%0d]: got %h expected %h", i, acc_log[i], seq_1234[i]);
      end
    end
    tests_run++;
    if (wr_log.size() > 0 && wr_log[0] !== {1'b0, 1'b1, 3'd2}) begin
      fails++;
      $display("FAIL stray_first_write: got %b expected 01010", wr_log[0]);
    end
    tick();
    tests_run++;
    if (obs_busy !== 1'b0) begin fails++; $display("FAIL stray_idle_gap: got busy=%b expected 0", obs_busy); end
    tick();
    tests_run++;
    if (!(obs_busy && obs_valid && obs_addr == 16'h4000)) begin
      fails++;
      $display("FAIL stray_next_miss: got busy=%b valid=%b addr=%h expected 1 1 4000", obs_busy, obs_valid, obs_addr);
    end
    miss_n = 1'b0;
    clear_logs();
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8) begin
      fails++;
      $display("FAIL stray_second_fill: got timeout=%b writes=%0d expected 0 8", to, wr_log.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit to;
    int tags;
    clear_logs();
    lat = 1; auto_ret = 1'b1; rdy_n = 1'b1; addr_n = 16'h1234; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    for (int i = 0; i < 30 && wr_log.size() < 3; i++) tick();
    tests_run++;
    if (wr_log.size() != 3) begin fails++; $display("FAIL rstmid_progress: got writes=%0d expected 3", wr_log.size()); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_if.mem_req_valid, fsm_busy, write_data_array, write_tag_array, critical_valid} !== 5'b0
        || mem_if.mem_address !== 16'h0000 || write_offset !== 3'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: got ctrl=%b addr=%h off=%0d expected 00000 0000 0",
               {mem_if.mem_req_valid, fsm_busy, write_data_array, write_tag_array, critical_valid},
               mem_if.mem_address, write_offset);
    end
    due_q.delete();
    auto_ret = 1'b0; dv_man = 1'b0;
    mem_if.mem_data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tags = 0;
    foreach (wr_log[i]) if (wr_log[i][4]) tags++;
    tests_run++;
    if (tags != 0) begin fails++; $display("FAIL rstmid_no_tag: got %0d tag writes expected 0", tags); end
    clear_logs();
    auto_ret = 1'b1; lat = 2; addr_n = 16'h00F0; miss_n = 1'b1;
    tick();
    miss_n = 1'b0;
    tick();
    tests_run++;
    if (!(obs_valid && obs_addr == 16'h00F0)) begin
      fails++;
      $display("FAIL rstmid_restart: got valid=%b addr=%h expected 1 00f0", obs_valid, obs_addr);
    end
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8 || wr_log[0] !== {1'b0, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL rstmid_refill: got timeout=%b writes=%0d expected 0 8 with first write crit at offset 0",
               to, wr_log.size());
    end
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      tests_run++;
      if (acc_log[i] !== seq_00f0[i]) begin
        fails++;
        $display("FAIL rstmid_addr[%0d]: got %h expected %h", i, acc_log[i], seq_00f0[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_logs();
    lat = 4; auto_ret = 1'b1; rdy_n = 1'b1; addr_n = 16'h1234; miss_n = 1'b1;
    tick();
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8 || acc_log.size() != 8) begin
      fails++;
      $display("FAIL b2b_first: got timeout=%b writes=%0d acc=%0d expected 0 8 8", to, wr_log.size(), acc_log.size());
    end
    clear_logs();
    addr_n = 16'h5678;
    tick();
    tests_run++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle_cycle: got busy=%b valid=%b expected 0 0", obs_busy, obs_valid);
    end
    miss_n = 1'b0;
    tick();
    tests_run++;
    if (!(obs_busy && obs_valid && obs_addr == 16'h5678)) begin
      fails++;
      $display("FAIL b2b_second_req: got busy=%b valid=%b addr=%h expected 1 1 5678", obs_busy, obs_valid, obs_addr);
    end
    drain(60, to);
    tests_run++;
    if (to || wr_log.size() != 8 || wr_log[0] !== {1'b0, 1'b1, 3'd4}) begin
      fails++;
      $display("FAIL b2b_second_fill: got timeout=%b writes=%0d expected 0 8 with first write crit at offset 4",
               to, wr_log.size());
    end
    tick();
    tests_run++;
    if (obs_busy !== 1'b0) begin fails++; $display("FAIL b2b_done_busy: got %b expected 0", obs_busy); end
  endtask

  initial begin
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_data_valid = 1'b0;
    test_reset();
    test_crit_first();
    test_backpressure();
    test_out_cap();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
